registro_universal: RTL



---
 rtl/registro_universal.sv | 91 +++++++++
 1 files changed

// File: rtl/registro_universal.sv
// Universal N-bit shift register: rotate, serial shift, parallel load,
// with serial output, modulo-N shift counter and FULL pulse. Option: PARIDAD_EN.
module registro_universal #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          CLK,
  input  logic          RESET_L,
  input  logic          ENB,
  input  logic          DIR,
  input  logic [1:0]    MODO,
  input  logic          S_IN,
  input  logic [N-1:0]  D,
  output logic [N-1:0]  Q,
  output logic          S_OUT,
  output logic [CW-1:0] CNT,
`ifdef PARIDAD_EN
  output logic          FULL,
  output logic          PAR
`else
  output logic          FULL
`endif
);

  logic [N-1:0] qNext;
  logic         sNext;
  logic         doShift;
  logic         edgeLo;
  logic         edgeHi;
  logic         lastCnt;

  // Edge-bit sources: serial input in shift mode, wrapped bit in rotate mode
  assign edgeLo  = MODO[0] ? S_IN : Q[N-1];
  assign edgeHi  = MODO[0] ? S_IN : Q[0];
  assign lastCnt = (CNT == CW'(N-1));

  // Per-bit next-state selection and shifted-out bit
  always_comb begin
    qNext   = Q;
    sNext   = S_OUT;
    doShift = 1'b0;
    unique case (1'b1)
      MODO[1]: begin
        qNext = D;
      end
      !MODO[1] && DIR: begin
        doShift = 1'b1;
        qNext   = {Q[N-2:0], edgeLo};
        sNext   = Q[N-1];
      end
      !MODO[1] && !DIR: begin
        doShift = 1'b1;
        qNext   = {edgeHi, Q[N-1:1]};
        sNext   = Q[0];
      end
    endcase
  end

  // Register bank, serial output and shift counter
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q     <= '0;
      S_OUT <= 1'b0;
      CNT   <= '0;
      FULL  <= 1'b0;
    end else if (ENB) begin
      Q     <= qNext;
      S_OUT <= sNext;
      if (doShift) begin
        CNT  <= lastCnt ? '0 : CNT + 1'b1;
        FULL <= lastCnt;
      end else begin
        CNT  <= '0;
        FULL <= 1'b0;
      end
    end else begin
      FULL <= 1'b0;
    end
  end

`ifdef PARIDAD_EN
  // Parity tracks the value being written into Q
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L)
      PAR <= 1'b0;
    else if (ENB)
      PAR <= ^qNext;
  end
`endif

endmodule
